// File: rtl/mrd_bfp_stage_tracker.sv
// Block-floating-point headroom tracker behind the radix-5 butterfly: forwards vectors
// and reports the stage's minimum margin and exponent. Optional MRD_BFP_EXP_CHECK_EN adds exp_err.
module mrd_bfp_stage_tracker #(
    parameter int DW         = 18,
    parameter int CNT_W      = 12,
    parameter int MARGIN_MAX = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_W-1:0]     num_bfly,
    input  logic                 in_val,
    input  logic signed [DW-1:0] din_real [0:4],
    input  logic signed [DW-1:0] din_imag [0:4],
    input  logic [3:0]           exp_in,
    output logic                 out_val,
    output logic signed [DW-1:0] dout_real [0:4],
    output logic signed [DW-1:0] dout_imag [0:4],
    output logic                 busy,
    output logic                 stage_done,
    output logic [1:0]           margin_out,
    output logic [3:0]           exp_stage,
    output logic                 seq_err
`ifdef MRD_BFP_EXP_CHECK_EN
    ,
    output logic                 exp_err
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    localparam logic [1:0]       M_MAX = 2'(MARGIN_MAX);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] ZERO  = CNT_W'(0);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] num_lat;
    logic [3:0]       exp_acc;
    logic [1:0]       running_min;
    logic [1:0]       vec_margin;
    logic             counted;

    logic [1:0]       vec_margin_c;
    logic             start_ok;
    logic             count_c;
    logic             first_c;
    logic             last_c;

    // Length of the run of bits below the sign that repeat it, saturated at MARGIN_MAX.
    function automatic logic [1:0] sample_margin(input logic [DW-1:0] x);
        logic [1:0] m;
        logic       run;
        m   = 2'd0;
        run = 1'b1;
        for (int k = 1; k <= MARGIN_MAX; k++) begin
            if (run && (x[DW-1-k] == x[DW-1])) begin
                m = m + 2'd1;
            end else begin
                run = 1'b0;
            end
        end
        return m;
    endfunction

    function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
        return (a < b) ? a : b;
    endfunction

    assign busy = (state == RUN) || (state == FLUSH);

    // Worst-case margin over the ten incoming samples.
    always_comb begin
        vec_margin_c = M_MAX;
        for (int i = 0; i < 5; i++) begin
            vec_margin_c = min2(vec_margin_c, sample_margin(din_real[i]));
            vec_margin_c = min2(vec_margin_c, sample_margin(din_imag[i]));
        end
    end

    // Decide whether the current vector belongs to a stage, and its position in it.
    always_comb begin
        start_ok = start && (num_bfly != ZERO);
        if (start_ok) begin
            count_c = in_val;
            first_c = 1'b1;
            last_c  = (num_bfly == ONE);
        end else if (state == RUN) begin
            count_c = in_val;
            first_c = (cnt == ZERO);
            last_c  = (cnt == (num_lat - ONE));
        end else begin
            count_c = 1'b0;
            first_c = 1'b0;
            last_c  = 1'b0;
        end
    end

    // Stage-control FSM with its registered result outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= ZERO;
            num_lat    <= ZERO;
            exp_acc    <= 4'd0;
            stage_done <= 1'b0;
            margin_out <= 2'd0;
            exp_stage  <= 4'd0;
            seq_err    <= 1'b0;
`ifdef MRD_BFP_EXP_CHECK_EN
            exp_err    <= 1'b0;
`endif
        end else begin
            stage_done <= (state == DONE);
            if (state == DONE) begin
                margin_out <= running_min;
                exp_stage  <= exp_acc;
            end
            if (in_val && (state == IDLE) && !start_ok) begin
                seq_err <= 1'b1;
            end
            if (count_c) begin
`ifdef MRD_BFP_EXP_CHECK_EN
                if (first_c) begin
                    exp_acc <= exp_in;
                end else if (exp_in != exp_acc) begin
                    exp_err <= 1'b1;
                end
`else
                exp_acc <= exp_in;
`endif
            end
            // A valid start restarts from any state; a stage in progress is dropped.
            if (start_ok) begin
                num_lat <= num_bfly;
                cnt     <= count_c ? ONE : ZERO;
                state   <= (count_c && last_c) ? FLUSH : RUN;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    RUN: begin
                        if (count_c) begin
                            cnt <= cnt + ONE;
                            if (last_c) begin
                                state <= FLUSH;
                            end
                        end
                    end
                    FLUSH:   state <= DONE;
                    DONE:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Pipe stage 1: unmodified pass-through plus the vector margin and its count tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_val    <= 1'b0;
            vec_margin <= 2'd0;
            counted    <= 1'b0;
            for (int i = 0; i < 5; i++) begin
                dout_real[i] <= '0;
                dout_imag[i] <= '0;
            end
        end else begin
            out_val    <= in_val;
            vec_margin <= vec_margin_c;
            counted    <= count_c;
            dout_real  <= din_real;
            dout_imag  <= din_imag;
        end
    end

    // Pipe stage 2: fold counted vectors into the stage minimum; a restart discards in-flight folds.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_min <= M_MAX;
        end else if (start_ok) begin
            running_min <= M_MAX;
        end else if (counted) begin
            running_min <= min2(running_min, vec_margin);
        end
    end

endmodule

// File: tb/tb_mrd_bfp_stage_tracker.sv
// Directed and randomized bench for mrd_bfp_stage_tracker; expected margins come from a
// range-based model of sign headroom. Covers MRD_BFP_EXP_CHECK_EN when it is defined.
module tb_mrd_bfp_stage_tracker;

    localparam int DW    = 18;
    localparam int CNT_W = 12;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic [CNT_W-1:0]     num_bfly;
    logic                 in_val;
    logic signed [DW-1:0] din_real [0:4];
    logic signed [DW-1:0] din_imag [0:4];
    logic [3:0]           exp_in;
    logic                 out_val;
    logic signed [DW-1:0] dout_real [0:4];
    logic signed [DW-1:0] dout_imag [0:4];
    logic                 busy;
    logic                 stage_done;
    logic [1:0]           margin_out;
    logic [3:0]           exp_stage;
    logic                 seq_err;
`ifdef MRD_BFP_EXP_CHECK_EN
    logic                 exp_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    bit exp_seq  = 1'b0;
    bit exp_errm = 1'b0;

    logic signed [DW-1:0] st_re [0:15][0:4];
    logic signed [DW-1:0] st_im [0:15][0:4];
    logic [3:0]           st_exp [0:15];
    logic signed [DW-1:0] p_re [0:4];
    logic signed [DW-1:0] p_im [0:4];
    logic                 p_val;

    mrd_bfp_stage_tracker dut (
        .clk(clk), .rst(rst), .start(start), .num_bfly(num_bfly), .in_val(in_val),
        .din_real(din_real), .din_imag(din_imag), .exp_in(exp_in),
        .out_val(out_val), .dout_real(dout_real), .dout_imag(dout_imag),
        .busy(busy), .stage_done(stage_done), .margin_out(margin_out),
        .exp_stage(exp_stage), .seq_err(seq_err)
`ifdef MRD_BFP_EXP_CHECK_EN
        , .exp_err(exp_err)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Headroom = largest k such that x fits in DW-k signed bits, capped at 3.
    function automatic int margin_of(input logic signed [DW-1:0] x);
        int v;
        v = x;
        for (int k = 3; k >= 1; k--) begin
            if (v >= -(1 << (DW - 1 - k)) && v < (1 << (DW - 1 - k))) return k;
        end
        return 0;
    endfunction

    function automatic logic signed [DW-1:0] rnd_sample();
        logic signed [DW-1:0] t;
        t = DW'($urandom);
        return t >>> $urandom_range(0, 4);
    endfunction

    task automatic tick();
        p_val = in_val;
        for (int j = 0; j < 5; j++) begin
            p_re[j] = din_real[j];
            p_im[j] = din_imag[j];
        end
        @(posedge clk);
        #1;
        chk("out_val", {31'd0, out_val}, {31'd0, p_val});
        for (int j = 0; j < 5; j++) begin
            chk("dout_real", dout_real[j], p_re[j]);
            chk("dout_imag", dout_imag[j], p_im[j]);
        end
    endtask

    task automatic fill_vec(input int idx, input logic signed [DW-1:0] re,
                            input logic signed [DW-1:0] im, input logic [3:0] e);
        for (int j = 0; j < 5; j++) begin
            st_re[idx][j] = re;
            st_im[idx][j] = im;
        end
        st_exp[idx] = e;
    endtask

    task automatic load_vec(input int idx);
        for (int j = 0; j < 5; j++) begin
            din_real[j] = st_re[idx][j];
            din_imag[j] = st_im[idx][j];
        end
        exp_in = st_exp[idx];
    endtask

    // One full stage of n stored vectors; optionally vector 0 rides on the start cycle.
    task automatic run_stage(input int n, input bit vos, input string tag);
        int         mn;
        int         gap;
        logic [3:0] ex;
        mn = 3;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 5; j++) begin
                if (margin_of(st_re[i][j]) < mn) mn = margin_of(st_re[i][j]);
                if (margin_of(st_im[i][j]) < mn) mn = margin_of(st_im[i][j]);
            end
            if (i > 0 && st_exp[i] != st_exp[0]) exp_errm = 1'b1;
        end
`ifdef MRD_BFP_EXP_CHECK_EN
        ex = st_exp[0];
`else
        ex = st_exp[n-1];
`endif
        num_bfly = CNT_W'(n);
        start    = 1'b1;
        in_val   = 1'b0;
        if (!vos) begin
            tick();
            start = 1'b0;
            chk({tag, "_busy_start"}, {31'd0, busy}, 32'd1);
        end
        for (int i = 0; i < n; i++) begin
            load_vec(i);
            in_val = 1'b1;
            tick();
            start  = 1'b0;
            in_val = 1'b0;
            if (i < n - 1) begin
                chk({tag, "_busy_run"}, {31'd0, busy}, 32'd1);
                gap = $urandom_range(0, 1);
                for (int g = 0; g < gap; g++) tick();
            end
        end
        chk({tag, "_flush_nodone"}, {31'd0, stage_done}, 32'd0);
        chk({tag, "_flush_busy"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, "_done_early"}, {31'd0, stage_done}, 32'd0);
        chk({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
        tick();
        chk({tag, "_stage_done"}, {31'd0, stage_done}, 32'd1);
        chk({tag, "_margin"}, {30'd0, margin_out}, 32'(mn));
        chk({tag, "_exp_stage"}, {28'd0, exp_stage}, {28'd0, ex});
        chk({tag, "_seq_err"}, {31'd0, seq_err}, {31'd0, exp_seq});
`ifdef MRD_BFP_EXP_CHECK_EN
        chk({tag, "_exp_err"}, {31'd0, exp_err}, {31'd0, exp_errm});
`endif
        tick();
        chk({tag, "_done_pulse"}, {31'd0, stage_done}, 32'd0);
        chk({tag, "_margin_hold"}, {30'd0, margin_out}, 32'(mn));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_bfly = '0; in_val = 1'b0; exp_in = 4'd0;
        for (int j = 0; j < 5; j++) begin
            din_real[j] = '0;
            din_imag[j] = '0;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_val", {31'd0, out_val}, 32'd0);
        chk("rst_stage_done", {31'd0, stage_done}, 32'd0);
        chk("rst_margin", {30'd0, margin_out}, 32'd0);
        chk("rst_exp_stage", {28'd0, exp_stage}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_seq_err", {31'd0, seq_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // All-small vectors: margin 3.
        for (int i = 0; i < 4; i++) fill_vec(i, 18'sh00100, 18'sh00100, 4'd6);
        run_stage(4, 1'b0, "t1");

        // One sample with no headroom in vector 2.
        for (int i = 0; i < 3; i++) fill_vec(i, 18'sh00010, -18'sh00020, 4'd7);
        st_re[1][3] = 18'sh1FFFF;
        run_stage(3, 1'b0, "t2");

        // Single-vector stage mixing margins 1 and 2.
        fill_vec(0, 18'sh0C000, -18'sh08000, 4'd9);
        run_stage(1, 1'b0, "t3");

        // Stray vector in IDLE, then a zero-length start.
        fill_vec(0, 18'sh00123, -18'sh00456, 4'd1);
        load_vec(0);
        in_val = 1'b1;
        tick();
        in_val  = 1'b0;
        exp_seq = 1'b1;
        chk("idle_seq_err", {31'd0, seq_err}, 32'd1);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        num_bfly = '0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        chk("zero_start_busy", {31'd0, busy}, 32'd0);
        tick();
        chk("zero_start_busy2", {31'd0, busy}, 32'd0);
        chk("zero_start_nodone", {31'd0, stage_done}, 32'd0);

        // Abort after two low-margin vectors; the restarted stage sees only new data.
        fill_vec(0, 18'sh1FFFF, 18'sh1FFFF, 4'd3);
        num_bfly = 12'd5;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_vec(0);
            in_val = 1'b1;
            tick();
            in_val = 1'b0;
        end
        for (int i = 0; i < 5; i++) fill_vec(i, 18'sh00100, -18'sh00100, 4'd3);
        run_stage(5, 1'b0, "abort");
        chk("abort_busy_after", {31'd0, busy}, 32'd0);

        // Start issued while DONE: the pulse still comes and the next stage begins at once.
        fill_vec(0, 18'sh0C000, 18'sh0C000, 4'd2);
        num_bfly = 12'd1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        load_vec(0);
        in_val = 1'b1;
        tick();
        in_val = 1'b0;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("chain_stage_done", {31'd0, stage_done}, 32'd1);
        chk("chain_margin", {30'd0, margin_out}, 32'd1);
        chk("chain_busy", {31'd0, busy}, 32'd1);
        fill_vec(0, 18'sh00100, 18'sh00100, 4'd2);
        load_vec(0);
        in_val = 1'b1;
        tick();
        in_val = 1'b0;
        tick();
        tick();
        chk("chain2_stage_done", {31'd0, stage_done}, 32'd1);
        chk("chain2_margin", {30'd0, margin_out}, 32'd3);

        // Exponent changes within a stage: 4, 4, 5.
        fill_vec(0, 18'sh00200, 18'sh00200, 4'd4);
        fill_vec(1, 18'sh00200, 18'sh00200, 4'd4);
        fill_vec(2, 18'sh00200, 18'sh00200, 4'd5);
        run_stage(3, 1'b0, "expchk");

        // Randomized stages.
        for (int s = 0; s < 20; s++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < 5; j++) begin
                    st_re[i][j] = rnd_sample();
                    st_im[i][j] = rnd_sample();
                end
                st_exp[i] = 4'($urandom_range(0, 15));
            end
            run_stage(n, 1'($urandom_range(0, 1)), "rand");
        end

        // Asynchronous reset in the middle of a stage.
        for (int i = 0; i < 4; i++) fill_vec(i, 18'sh00100, 18'sh00100, 4'd8);
        num_bfly = 12'd4;
        start    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            load_vec(i);
            in_val = 1'b1;
            tick();
        end
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_val", {31'd0, out_val}, 32'd0);
        chk("arst_dout", dout_real[0], 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_margin", {30'd0, margin_out}, 32'd0);
        chk("arst_exp_stage", {28'd0, exp_stage}, 32'd0);
        chk("arst_seq_err", {31'd0, seq_err}, 32'd0);
`ifdef MRD_BFP_EXP_CHECK_EN
        chk("arst_exp_err", {31'd0, exp_err}, 32'd0);
`endif
        in_val = 1'b0;
        @(negedge clk);
        rst      = 1'b0;
        exp_seq  = 1'b0;
        exp_errm = 1'b0;

        // Fresh stage after reset: partial stage is gone.
        fill_vec(0, 18'sh04000, 18'sh00100, 4'd11);
        fill_vec(1, 18'sh00100, 18'sh00100, 4'd11);
        run_stage(2, 1'b1, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
